out_port_uart_tx: RTL

Output-side peripheral for the OUT instruction. It captures the 16-bit register-file word presented whenever the control unit pulses `output_valid`, and buffers it in a small FIFO. It then serializes each word as two 8N1 UART bytes on `tx`, low byte first. The core cannot stall, so the block never back-pressures: it drops writes while full and records a sticky overflow.

---
 rtl/turtle_io_pkg.sv | 17 +
 rtl/word_fifo.sv | 70 +++++++
 rtl/out_port_uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/turtle_io_pkg.sv
// Shared definitions for the turtle I/O peripherals.
//   tx_state_t                 : UART transmitter FSM states
//   UART_CLKS_PER_BIT_DEFAULT  : default baud divisor (core clocks per bit)
//   OUT_FIFO_DEPTH_DEFAULT     : default OUT-port FIFO depth in words
package turtle_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
  localparam int OUT_FIFO_DEPTH_DEFAULT    = 4;

endpackage

// File: rtl/word_fifo.sv
// Single-clock synchronous FIFO with registered full/empty flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write strobe and data (ignored while full)
//   pop        : read strobe (ignored while empty); rdata shows the head word
//   full/empty : registered occupancy flags
module word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    // Flags are computed from the next pointers so the registered copies
    // change on the same edge as the push/pop that affects them.
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  // Head word is visible combinationally so the consumer can pop and load it
  // on the same edge.
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/out_port_uart_tx.sv
// OUT-instruction peripheral: buffers 16-bit words and sends each as two
// 8N1 UART bytes (low byte first). Never back-pressures the core.
//   clk, rst_n    : core clock, asynchronous active-low reset
//   output_valid  : one-cycle push strobe; out_data sampled with it
//   ovf_clr       : clears the sticky overflow flag (a same-cycle drop wins)
//   tx            : registered serial line, idle high
//   fifo_full/empty : registered FIFO occupancy flags
//   busy          : transmitter is mid-word
//   overflow      : sticky, a push arrived while the FIFO was full
module out_port_uart_tx
  import turtle_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = OUT_FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        output_valid,
  input  logic [15:0] out_data,
  input  logic        ovf_clr,
  output logic        tx,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = {{(CW-1){1'b0}}, 1'b1};

  tx_state_t   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_hi_q, byte_hi_d;
  logic [15:0] hold_q, hold_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic        push_en, drop, fifo_pop, baud_done;
  logic [15:0] fifo_rdata;
  logic [7:0]  cur_byte;

  // A push seen while full is lost even if the FSM pops in the same cycle,
  // because the full flag is the registered one.
  assign push_en = output_valid && !fifo_full;
  assign drop    = output_valid && fifo_full;

  word_fifo #(
    .WIDTH(16),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_en),
    .wdata(out_data),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    byte_hi_d = byte_hi_q;
    hold_d    = hold_q;
    fifo_pop  = 1'b0;
    baud_done = (baud_q == BAUD_LAST);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          hold_d    = fifo_rdata;
          byte_hi_d = 1'b0;
          baud_d    = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // High byte follows the low byte with no idle gap.
          if (!byte_hi_q) begin
            byte_hi_d = 1'b1;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is derived from the next state so the registered line changes on the
    // same edge as the state it belongs to.
    cur_byte = byte_hi_d ? hold_d[15:8] : hold_d[7:0];
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase

    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      byte_hi_q <= 1'b0;
      hold_q    <= 16'h0000;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      byte_hi_q <= byte_hi_d;
      hold_q    <= hold_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;

endmodule
